// File: rtl/jtag_tdo_capture_pkg.sv
// Shared types and default widths for the TDO capture block.
package jtag_pkg;

  localparam int CAP_DATA_W = 8;
  localparam int CAP_LEN_W  = 16;

  typedef enum logic {
    IDLE,
    SHIFT
  } cap_state_e;

  typedef struct packed {
    logic                  last;
    logic [CAP_DATA_W-1:0] data;
  } cap_word_t;

endpackage

// File: rtl/jtag_tdo_capture_if.sv
// Host read port: valid/ready stream of captured bytes.
interface jtag_tdo_capture_if #(
  parameter int DATA_W = jtag_pkg::CAP_DATA_W
) ();

  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;
  logic              rd_ready;

  modport master (
    output rd_valid,
    output rd_data,
    output rd_last,
    input  rd_ready
  );

  modport slave (
    input  rd_valid,
    input  rd_data,
    input  rd_last,
    output rd_ready
  );

endinterface

// File: rtl/jtag_byte_fifo.sv
// Synchronous first-word-fall-through FIFO of captured words.
module jtag_byte_fifo
  import jtag_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  cap_word_t                push_word,
  input  logic                     pop,
  output cap_word_t                head_word,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;
  cap_word_t     mem_q [DEPTH];
  logic          pop_ok;
  logic          push_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign level   = count_q;
  assign pop_ok  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push_ok = push && (!full || pop_ok);
  assign head_word = empty ? '0 : mem_q[rd_ptr_q];

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_word;
  end

endmodule

// File: rtl/jtag_tdo_capture.sv
// Samples TDO during Shift-IR/DR, packs bits LSB-first into bytes, buffers them.
module jtag_tdo_capture
  import jtag_pkg::*;
#(
  parameter int DATA_W     = CAP_DATA_W,
  parameter int LEN_W      = CAP_LEN_W,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [LEN_W-1:0]              len,
  input  logic                          shift_en,
  input  logic                          tck_rise,
  input  logic                          tdo,
  jtag_tdo_capture_if.master            rd,
  output logic                          busy,
  output logic                          done,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int BW = $clog2(DATA_W);

  cap_state_e        state_q,     state_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic [BW-1:0]     bitpos_q,    bitpos_d;
  logic [DATA_W-1:0] shreg_q,     shreg_d;
  logic              overflow_q,  overflow_d;
  logic              done_q,      done_d;

  logic              push;
  logic              pop;
  cap_word_t         push_word;
  cap_word_t         head_word;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] cap;
  logic              last_bit;

  assign pop         = rd.rd_valid && rd.rd_ready;
  assign rd.rd_valid = !fifo_empty;
  assign rd.rd_data  = head_word.data;
  assign rd.rd_last  = head_word.last;
  assign busy        = (state_q == SHIFT);
  assign done        = done_q;
  assign overflow    = overflow_q;
  assign last_bit    = (remaining_q == LEN_W'(1));

  // Capture FSM, bit packing and overflow tracking.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    bitpos_d    = bitpos_q;
    shreg_d     = shreg_q;
    overflow_d  = overflow_q;
    done_d      = 1'b0;
    push        = 1'b0;
    push_word   = '0;
    cap         = shreg_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            remaining_d = len;
            bitpos_d    = '0;
            shreg_d     = '0;
            overflow_d  = 1'b0;
            state_d     = SHIFT;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (tck_rise && shift_en) begin
          cap[bitpos_q] = tdo;
          remaining_d   = remaining_q - 1'b1;
          // Clearing shreg on every push keeps unfilled upper bits of a partial byte at 0.
          if (bitpos_q == BW'(DATA_W-1) || last_bit) begin
            push           = 1'b1;
            push_word.last = last_bit;
            push_word.data = cap;
            shreg_d        = '0;
            bitpos_d       = '0;
            if (fifo_full && !pop) overflow_d = 1'b1;
          end else begin
            shreg_d  = cap;
            bitpos_d = bitpos_q + 1'b1;
          end
          if (last_bit) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      bitpos_q    <= '0;
      shreg_q     <= '0;
      overflow_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      bitpos_q    <= bitpos_d;
      shreg_q     <= shreg_d;
      overflow_q  <= overflow_d;
      done_q      <= done_d;
    end
  end

  jtag_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_word (push_word),
    .pop       (pop),
    .head_word (head_word),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level)
  );

endmodule

// File: tb/tb_jtag_tdo_capture.sv
// Directed bench for jtag_tdo_capture.
module tb_jtag_tdo_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] len;
  logic        shift_en;
  logic        tck_rise;
  logic        tdo;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [4:0]  level;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  jtag_tdo_capture_if #(.DATA_W(8)) rd_if ();

  jtag_tdo_capture #(
    .DATA_W     (8),
    .LEN_W      (16),
    .FIFO_DEPTH (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .len      (len),
    .shift_en (shift_en),
    .tck_rise (tck_rise),
    .tdo      (tdo),
    .rd       (rd_if.master),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .level    (level)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic b, input logic se);
    tck_rise = 1'b1;
    shift_en = se;
    tdo      = b;
    tick();
    tck_rise = 1'b0;
    shift_en = 1'b0;
  endtask

  task automatic kick(input logic [15:0] n);
    start = 1'b1;
    len   = n;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; len = '0; shift_en = 1'b0;
    tck_rise = 1'b0; tdo = 1'b0; rd_if.rd_ready = 1'b0;
    tick(); tick();
    // Reset state
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_level", level, 0);
    chk("rst_valid", rd_if.rd_valid, 0);
    chk("rst_data", rd_if.rd_data, 0);
    chk("rst_last", rd_if.rd_last, 0);
    rst = 1'b1;
    tick();

    // 1: len=10, alternating 1,0 with rd_ready=1 -> 0x55, then 0x01 last
    rd_if.rd_ready = 1'b1;
    kick(16'd10);
    chk("t1_busy", busy, 1);
    for (int i = 0; i < 8; i++) strobe(~i[0], 1'b1);
    chk("t1_valid0", rd_if.rd_valid, 1);
    chk("t1_data0", rd_if.rd_data, 8'h55);
    chk("t1_last0", rd_if.rd_last, 0);
    chk("t1_lvl0", level, 1);
    chk("t1_nodone", done, 0);
    tick();
    chk("t1_popped", level, 0);
    strobe(1'b1, 1'b1);
    strobe(1'b0, 1'b1);
    chk("t1_data1", rd_if.rd_data, 8'h01);
    chk("t1_last1", rd_if.rd_last, 1);
    chk("t1_done", done, 1);
    chk("t1_idle", busy, 0);
    tick();
    chk("t1_done_off", done, 0);
    chk("t1_empty", rd_if.rd_valid, 0);

    // 2: len=8 all ones -> single 0xFF last
    rd_if.rd_ready = 1'b0;
    kick(16'd8);
    for (int i = 0; i < 8; i++) strobe(1'b1, 1'b1);
    chk("t2_data", rd_if.rd_data, 8'hFF);
    chk("t2_last", rd_if.rd_last, 1);
    chk("t2_lvl1", level, 1);
    chk("t2_done", done, 1);
    chk("t2_busy", busy, 0);
    tick();
    chk("t2_hold", rd_if.rd_data, 8'hFF);
    rd_if.rd_ready = 1'b1;
    tick();
    rd_if.rd_ready = 1'b0;
    chk("t2_lvl0", level, 0);

    // 3: ignored strobes interleaved, then len=0
    kick(16'd10);
    for (int i = 0; i < 10; i++) begin
      strobe(i[0], 1'b0);
      shift_en = 1'b1; tdo = i[0]; tick(); shift_en = 1'b0;
      strobe(~i[0], 1'b1);
    end
    chk("t3_lvl", level, 2);
    chk("t3_data0", rd_if.rd_data, 8'h55);
    chk("t3_last0", rd_if.rd_last, 0);
    rd_if.rd_ready = 1'b1; tick(); rd_if.rd_ready = 1'b0;
    chk("t3_data1", rd_if.rd_data, 8'h01);
    chk("t3_last1", rd_if.rd_last, 1);
    rd_if.rd_ready = 1'b1; tick(); rd_if.rd_ready = 1'b0;
    chk("t3_lvl0", level, 0);
    kick(16'd0);
    chk("t3_len0_done", done, 1);
    chk("t3_len0_busy", busy, 0);
    chk("t3_len0_valid", rd_if.rd_valid, 0);
    tick();
    chk("t3_len0_done_off", done, 0);

    // 4: overflow with rd_ready=0, len=136
    kick(16'd136);
    for (int i = 0; i < 128; i++) strobe(1'b1, 1'b1);
    chk("t4_full", level, 16);
    chk("t4_noovf", overflow, 0);
    for (int i = 0; i < 8; i++) strobe(1'b1, 1'b1);
    chk("t4_lvl", level, 16);
    chk("t4_ovf", overflow, 1);
    chk("t4_done", done, 1);
    rd_if.rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("t4_drain_data", rd_if.rd_data, 8'hFF);
      chk("t4_drain_last", rd_if.rd_last, 0);
      tick();
    end
    rd_if.rd_ready = 1'b0;
    chk("t4_empty", level, 0);
    chk("t4_ovf_sticky", overflow, 1);

    // 5: accepted start clears overflow; reset mid-scan
    kick(16'd20);
    chk("t5_ovf_clr", overflow, 0);
    for (int i = 0; i < 5; i++) strobe(1'b1, 1'b1);
    rst = 1'b0; tick(); rst = 1'b1;
    chk("t5_busy", busy, 0);
    chk("t5_lvl", level, 0);
    chk("t5_valid", rd_if.rd_valid, 0);
    kick(16'd8);
    strobe(1'b1, 1'b1); strobe(1'b1, 1'b1); strobe(1'b0, 1'b1); strobe(1'b0, 1'b1);
    strobe(1'b1, 1'b1); strobe(1'b0, 1'b1); strobe(1'b1, 1'b1); strobe(1'b0, 1'b1);
    chk("t5_data", rd_if.rd_data, 8'h53);
    chk("t5_last", rd_if.rd_last, 1);
    chk("t5_lvl1", level, 1);
    rd_if.rd_ready = 1'b1; tick(); rd_if.rd_ready = 1'b0;

    // 6: push into full FIFO with simultaneous pop; start ignored while busy
    kick(16'd136);
    for (int i = 0; i < 128; i++) begin
      if (i == 50) begin start = 1'b1; len = 16'd5; end
      strobe(1'b1, 1'b1);
      start = 1'b0;
    end
    chk("t6_busy", busy, 1);
    chk("t6_full", level, 16);
    for (int i = 0; i < 7; i++) strobe(1'b1, 1'b1);
    rd_if.rd_ready = 1'b1;
    strobe(1'b1, 1'b1);
    rd_if.rd_ready = 1'b0;
    chk("t6_lvl", level, 16);
    chk("t6_noovf", overflow, 0);
    chk("t6_done", done, 1);
    rd_if.rd_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      chk("t6_drain_data", rd_if.rd_data, 8'hFF);
      chk("t6_drain_last", rd_if.rd_last, 0);
      tick();
    end
    chk("t6_final_data", rd_if.rd_data, 8'hFF);
    chk("t6_final_last", rd_if.rd_last, 1);
    tick();
    rd_if.rd_ready = 1'b0;
    chk("t6_empty", level, 0);
    chk("t6_valid", rd_if.rd_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
